load_mem_unit: RTL
==================

Name: load_mem_unit

Overview:
Downstream consumer of the load data queue issue port. Buffers issued loads in a small FIFO and holds each load until all older stores have retired from the store data queue. It then performs the data-memory access through a valid/ready request and response interface and returns the load result to writeback. One memory access is outstanding at a time, and loads complete in issue order.

Parameters:
SDQ_ENTRIES, 8, store data queue depth; SDQ_PTR_W = $clog2(SDQ_ENTRIES)+1 (includes the wrap bit)
FIFO_DEPTH, 4, input FIFO entries (power of 2, at least 2)
TAG_W, 6, destination tag width carried to writeback

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
issue_vld  in  1  load issued by the LDQ this cycle (no backpressure at the LDQ)
issue_addr  in  32  load address
issue_sdq_marker  in  SDQ_PTR_W  SDQ tail pointer captured at dispatch
issue_tag  in  TAG_W  destination tag
fifo_full  out  1  FIFO holds FIFO_DEPTH entries (stall hint for upstream)
overflow_err  out  1  sticky: an issue was dropped because the FIFO was full
sdq_retire_ptr  in  SDQ_PTR_W  pointer to the oldest unretired store
flush  in  1  pipeline flush; discard all pending loads
mem_req_vld  out  1  memory read request
mem_req_rdy  in  1  memory accepts the request
mem_req_addr  out  32  request address
mem_resp_vld  in  1  read data valid (single cycle)
mem_resp_data  in  32  read data
wb_vld  out  1  result valid
wb_rdy  in  1  writeback accepts the result
wb_tag  out  TAG_W  result tag
wb_data  out  32  result data

Behaviour:
- Reset (rst=0): FIFO empty and pointers 0; state IDLE. All outputs are 0: fifo_full, overflow_err, mem_req_vld, mem_req_addr, wb_vld, wb_tag, wb_data.
- FIFO push: issue_vld=1 and (not full, or a pop in the same cycle) and flush=0.
  - issue_vld=1 while full with no pop: entry dropped, overflow_err set. overflow_err clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH; an extra count/wrap bit distinguishes full from empty.
- SDQ clear condition for the head load: d = (head.sdq_marker - sdq_retire_ptr) mod 2^SDQ_PTR_W. The load is clear when d==0 or d>SDQ_ENTRIES; it is blocked when 1<=d<=SDQ_ENTRIES.
- FSM states: IDLE, WAIT_SDQ, REQ, RESP, WB, DRAIN.
  - IDLE: if the FIFO is non-empty, go to REQ when the head is clear, else go to WAIT_SDQ.
  - WAIT_SDQ: go to REQ when the head becomes clear.
  - REQ: mem_req_vld=1 and mem_req_addr=head.addr, held stable until mem_req_rdy=1; then go to RESP.
  - RESP: wait for mem_resp_vld. Data and tag are registered into wb_data/wb_tag; go to WB.
  - WB: wb_vld=1 until wb_rdy=1. On the handshake, pop the FIFO and go to IDLE.
- Latency: issue in cycle N, empty FIFO, SDQ clear, rdy high → mem_req_vld in cycle N+2. Response in cycle M → wb_vld in cycle M+1.
- Flush:
  - Empties the FIFO in the same cycle; any issue_vld in that cycle is dropped (flush wins).
  - From IDLE, WAIT_SDQ, REQ or WB: go to IDLE and deassert mem_req_vld/wb_vld next cycle. An un-handshaked request is withdrawn.
  - From RESP: go to DRAIN. DRAIN waits for mem_resp_vld, discards the data with no wb_vld, then goes to IDLE. Pushes are accepted during DRAIN.
  - Flush in the same cycle as a REQ handshake: the request counts as accepted; go to DRAIN.
- mem_resp_vld outside RESP/DRAIN is ignored.
- Reset mid-operation: immediate return to reset state; any later memory response is ignored (state IDLE).

Test Plan:
- Single load: issue addr=0x100, tag=5, marker=retire_ptr=3, rdy=1. → mem_req_vld in cycle N+2 with addr 0x100. resp data 0xDEADBEEF at cycle M → wb_vld at M+1, tag=5, data=0xDEADBEEF; FIFO empty after the wb handshake.
- SDQ ordering: SDQ_ENTRIES=8, marker=5, retire_ptr=2. → WAIT_SDQ, no request. retire_ptr steps to 5 → request the next cycle. Wrap case: marker=1, retire_ptr=15 → blocked; retire_ptr=1 → clear.
- Backpressure: mem_req_rdy=0 for 3 cycles → addr stable, vld held; wb_rdy=0 for 2 cycles → wb_vld/data stable; 4 back-to-back issues complete in order.
- Overflow: 5 issues on consecutive cycles while blocked → fifo_full=1 after the 4th, 5th dropped, overflow_err=1; only the first 4 tags written back.
- Flush in RESP with 2 queued loads: FIFO empties, DRAIN. The response arrives → no wb_vld, state IDLE. A new issue after that completes normally.
- Async reset asserted in WB → wb_vld=0 immediately; a stray mem_resp_vld after release produces no wb_vld.

Source files
------------

// File: rtl/load_mem_unit.sv
// Load memory unit: buffers issued loads in a small FIFO and holds each one until
// all older stores have retired. It then performs one memory read at a time and
// returns results to writeback in issue order.
module load_mem_unit #(
   parameter int SDQ_ENTRIES = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int TAG_W       = 6,
   localparam int SDQ_PTR_W  = $clog2(SDQ_ENTRIES) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_vld,
   input  logic [31:0]          issue_addr,
   input  logic [SDQ_PTR_W-1:0] issue_sdq_marker,
   input  logic [TAG_W-1:0]     issue_tag,
   output logic                 fifo_full,
   output logic                 overflow_err,
   input  logic [SDQ_PTR_W-1:0] sdq_retire_ptr,
   input  logic                 flush,
   output logic                 mem_req_vld,
   input  logic                 mem_req_rdy,
   output logic [31:0]          mem_req_addr,
   input  logic                 mem_resp_vld,
   input  logic [31:0]          mem_resp_data,
   output logic                 wb_vld,
   input  logic                 wb_rdy,
   output logic [TAG_W-1:0]     wb_tag,
   output logic [31:0]          wb_data
);
   localparam int FIFO_AW = $clog2(FIFO_DEPTH);
   localparam int FIFO_PW = FIFO_AW + 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_SDQ = 3'd1,
      REQ      = 3'd2,
      RESP     = 3'd3,
      WB       = 3'd4,
      DRAIN    = 3'd5
   } state_t;

   state_t state_reg, state_next;

   logic [31:0]          addr_mem   [FIFO_DEPTH];
   logic [SDQ_PTR_W-1:0] marker_mem [FIFO_DEPTH];
   logic [TAG_W-1:0]     tag_mem    [FIFO_DEPTH];

   logic [FIFO_PW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_PW-1:0]   fifo_count;
   logic                 fifo_empty;
   logic                 push, pop;
   logic                 overflow_reg;
   logic [TAG_W-1:0]     wb_tag_reg;
   logic [31:0]          wb_data_reg;

   logic [31:0]          head_addr;
   logic [SDQ_PTR_W-1:0] head_marker;
   logic [TAG_W-1:0]     head_tag;
   logic [SDQ_PTR_W-1:0] sdq_dist;
   logic                 head_clear;

   assign fifo_count  = wr_ptr_reg - rd_ptr_reg;
   assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full   = (fifo_count == FIFO_PW'(FIFO_DEPTH));
   assign head_addr   = addr_mem[rd_ptr_reg[FIFO_AW-1:0]];
   assign head_marker = marker_mem[rd_ptr_reg[FIFO_AW-1:0]];
   assign head_tag    = tag_mem[rd_ptr_reg[FIFO_AW-1:0]];

   // Distance from the retire pointer to the load's marker; 1..SDQ_ENTRIES means older stores remain.
   assign sdq_dist   = head_marker - sdq_retire_ptr;
   assign head_clear = (sdq_dist == '0) || (sdq_dist > SDQ_PTR_W'(SDQ_ENTRIES));

   assign pop  = (state_reg == WB) && wb_rdy && !flush;
   assign push = issue_vld && !flush && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg[FIFO_AW-1:0]]   <= issue_addr;
         marker_mem[wr_ptr_reg[FIFO_AW-1:0]] <= issue_sdq_marker;
         tag_mem[wr_ptr_reg[FIFO_AW-1:0]]    <= issue_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (issue_vld && !flush && fifo_full && !pop) overflow_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_tag_reg  <= '0;
         wb_data_reg <= '0;
      end else if (state_reg == RESP && mem_resp_vld && !flush) begin
         wb_tag_reg  <= head_tag;
         wb_data_reg <= mem_resp_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (!flush && !fifo_empty) state_next = head_clear ? REQ : WAIT_SDQ;
         end
         WAIT_SDQ: begin
            if (flush)           state_next = IDLE;
            else if (head_clear) state_next = REQ;
         end
         REQ: begin
            // An accepted request must still have its response absorbed, even when flushed.
            if (mem_req_rdy) state_next = flush ? DRAIN : RESP;
            else if (flush)  state_next = IDLE;
         end
         RESP: begin
            // A response arriving with the flush is discarded right here; nothing left to drain.
            if (mem_resp_vld) state_next = flush ? IDLE : WB;
            else if (flush)   state_next = DRAIN;
         end
         WB: begin
            if (flush || wb_rdy) state_next = IDLE;
         end
         DRAIN: begin
            if (mem_resp_vld) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_req_vld  = 1'b0;
      mem_req_addr = '0;
      wb_vld       = 1'b0;
      if (state_reg == REQ) begin
         mem_req_vld  = 1'b1;
         mem_req_addr = head_addr;
      end
      if (state_reg == WB) wb_vld = 1'b1;
   end

   assign overflow_err = overflow_reg;
   assign wb_tag       = wb_tag_reg;
   assign wb_data      = wb_data_reg;

endmodule
